// File: rtl/adder_key_pkg.sv
// Shared types and constants for the adder key loader.
package adder_key_pkg;

    localparam int KEY_W_DEF  = 64;
    localparam int DATA_W_DEF = 32;

    // Galois right-shift mask for x^64 + x^63 + x^61 + x^60 + 1.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Correct key for the companion locked adder.
    localparam logic [63:0] KEY_GOLD = 64'h5A3C_96E1_0F7B_D248;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRIVE,
        ST_CHECK,
        ST_VERDICT,
        ST_DONE
    } state_e;

    // One Galois step: shift right, fold the tap mask in when bit 0 falls out.
    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'd0);
    endfunction

endpackage

// File: rtl/adder_key_loader_lfsr.sv
// 64-bit Galois LFSR producing self-test operands.
module key_lfsr64
    import adder_key_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h0123_4567_89AB_CDEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [63:0] seed_i,
    input  logic        step_i,
    output logic [63:0] state_o
);

    logic [63:0] lfsr_q;
    logic [63:0] lfsr_d;

    // Seed load takes priority over stepping.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (step_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // State register; reset to the nonzero seed so the register is never all-zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/adder_key_loader.sv
// Loads the serial unlock key, applies it to the locked adder and
// verifies it with a fixed-length self-test before releasing it.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start_i after reset, key bus held at 0
// LOAD    | shifting in key bits over valid/ready
// DRIVE   | registering the next operand pair and its golden sum
// CHECK   | comparing the locked adder's result against golden
// VERDICT | single cycle: keep the key on pass, zero it on failure
// DONE    | result held until the next start_i
module adder_key_loader
    import adder_key_pkg::*;
#(
    parameter int          KEY_W     = KEY_W_DEF,
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int          NUM_TESTS = 16,
    parameter logic [63:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              key_bit_i,
    input  logic              key_valid_i,
    output logic              key_ready_o,
    output logic [KEY_W-1:0]  key_o,
    output logic [DATA_W-1:0] test_add1_o,
    output logic [DATA_W-1:0] test_add2_o,
    input  logic [DATA_W:0]   test_result_i,
    output logic              busy_o,
    output logic              unlocked_o,
    output logic              fail_o
);

    localparam int          BW       = $clog2(KEY_W);
    localparam logic [BW-1:0] LAST_BIT  = BW'(KEY_W - 1);
    localparam logic [7:0]    LAST_TEST = 8'(NUM_TESTS - 1);

    state_e              state_q,    state_d;
    logic [KEY_W-1:0]    shreg_q,    shreg_d;
    logic [BW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]          test_cnt_q, test_cnt_d;
    logic [KEY_W-1:0]    key_q,      key_d;
    logic [DATA_W-1:0]   add1_q,     add1_d;
    logic [DATA_W-1:0]   add2_q,     add2_d;
    logic [DATA_W:0]     golden_q,   golden_d;
    logic                mismatch_q, mismatch_d;
    logic                unlocked_q, unlocked_d;
    logic                fail_q,     fail_d;

    logic                lfsr_load;
    logic                lfsr_step_en;
    logic [63:0]         lfsr_state;

    key_lfsr64 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (lfsr_load),
        .seed_i  (LFSR_SEED),
        .step_i  (lfsr_step_en),
        .state_o (lfsr_state)
    );

    // Next-state and datapath updates for the load / drive / check sequence.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        test_cnt_d   = test_cnt_q;
        key_d        = key_q;
        add1_d       = add1_q;
        add2_d       = add2_q;
        golden_d     = golden_q;
        mismatch_d   = mismatch_q;
        unlocked_d   = unlocked_q;
        fail_d       = fail_q;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                shreg_d    = '0;
                bit_cnt_d  = '0;
                unlocked_d = 1'b0;
                fail_d     = 1'b0;
                if (start_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (key_valid_i) begin
                    shreg_d[bit_cnt_q] = key_bit_i;
                    bit_cnt_d          = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        key_d      = shreg_d;
                        test_cnt_d = '0;
                        mismatch_d = 1'b0;
                        lfsr_load  = 1'b1;
                        state_d    = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                add1_d       = lfsr_state[DATA_W-1:0];
                add2_d       = lfsr_state[2*DATA_W-1:DATA_W];
                golden_d     = {1'b0, lfsr_state[DATA_W-1:0]}
                             + {1'b0, lfsr_state[2*DATA_W-1:DATA_W]};
                lfsr_step_en = 1'b1;
                state_d      = ST_CHECK;
            end
            ST_CHECK: begin
                mismatch_d = mismatch_q | (test_result_i != golden_q);
                if (test_cnt_q == LAST_TEST) begin
                    state_d = ST_VERDICT;
                end else begin
                    test_cnt_d = test_cnt_q + 8'd1;
                    state_d    = ST_DRIVE;
                end
            end
            ST_VERDICT: begin
                if (mismatch_q) begin
                    fail_d = 1'b1;
                    key_d  = '0;
                end else begin
                    unlocked_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start_i) begin
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    unlocked_d = 1'b0;
                    fail_d     = 1'b0;
                    key_d      = '0;
                    state_d    = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state registers clear together on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            test_cnt_q <= '0;
            key_q      <= '0;
            add1_q     <= '0;
            add2_q     <= '0;
            golden_q   <= '0;
            mismatch_q <= 1'b0;
            unlocked_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            test_cnt_q <= test_cnt_d;
            key_q      <= key_d;
            add1_q     <= add1_d;
            add2_q     <= add2_d;
            golden_q   <= golden_d;
            mismatch_q <= mismatch_d;
            unlocked_q <= unlocked_d;
            fail_q     <= fail_d;
        end
    end

    assign key_ready_o = (state_q == ST_LOAD);
    assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_DRIVE)
                      || (state_q == ST_CHECK) || (state_q == ST_VERDICT);
    assign key_o       = key_q;
    assign test_add1_o = add1_q;
    assign test_add2_o = add2_q;
    assign unlocked_o  = unlocked_q;
    assign fail_o      = fail_q;

endmodule
